alu_rs: RTL

Reservation station feeding the ALU in the out-of-order RISC-V core. Holds up to `RS_SIZE` dispatched integer/branch micro-ops, captures missing source operands from the two result buses (ALU and LSB), and issues one ready micro-op per cycle to the ALU. It is the producer side of the ALU's `in_*` port group; it flushes completely on `rollback_config`.

---
 rtl/riscv_defs.sv | 50 +++++
 rtl/rs_pick.sv | 22 ++
 rtl/alu_rs.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_defs.sv
// Shared core definitions: tag/data widths, opcode constants and the
// result-bus snoop helper used wherever a pending operand watches the CDBs.
package riscv_defs;

    localparam int ROB_W    = 4;
    localparam int XLEN     = 32;
    localparam int OPCODE_W = 7;
    localparam int FUNCT3_W = 3;

    localparam logic [OPCODE_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_REG    = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;

    typedef logic [ROB_W-1:0] rob_tag_t;
    typedef logic [XLEN-1:0]  word_t;

    typedef struct packed {
        logic  hit;
        word_t val;
    } snoop_t;

    // The ALU bus wins when both buses carry the same tag.
    function automatic snoop_t cdb_snoop(
        input rob_tag_t q,
        input logic     alu_cfg,
        input rob_tag_t alu_tag,
        input word_t    alu_val,
        input logic     lsb_cfg,
        input rob_tag_t lsb_tag,
        input word_t    lsb_val
    );
        snoop_t r;
        if (alu_cfg && (q == alu_tag)) begin
            r.hit = 1'b1;
            r.val = alu_val;
        end else if (lsb_cfg && (q == lsb_tag)) begin
            r.hit = 1'b1;
            r.val = lsb_val;
        end else begin
            r.hit = 1'b0;
            r.val = {XLEN{1'b0}};
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_pick.sv
// Lowest-set-bit priority encoder: index of the first requesting slot and a
// flag saying whether any slot requested at all.
module rs_pick #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scanning from the top lets the lowest requesting index overwrite the rest.
    always_comb begin
        idx   = {IDX_W{1'b0}};
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            idx   = req[i] ? IDX_W'(i) : idx;
            found = found | req[i];
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched micro-ops, snoops both result
// buses for missing operands and issues the lowest-index ready entry each cycle.
module alu_rs
    import riscv_defs::*;
#(
    parameter int RS_SIZE = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                rollback_config,
    input  logic                in_config,
    input  logic [OPCODE_W-1:0] in_opcode,
    input  logic [FUNCT3_W-1:0] in_precise,
    input  logic [XLEN-1:0]     in_imm,
    input  logic [XLEN-1:0]     in_PC,
    input  logic [ROB_W-1:0]    in_rob_entry,
    input  logic [XLEN-1:0]     in_Vj,
    input  logic [XLEN-1:0]     in_Vk,
    input  logic [ROB_W-1:0]    in_Qj,
    input  logic [ROB_W-1:0]    in_Qk,
    input  logic                in_Qj_busy,
    input  logic                in_Qk_busy,
    input  logic                in_alu_cdb_config,
    input  logic [ROB_W-1:0]    in_alu_cdb_rob_entry,
    input  logic [XLEN-1:0]     in_alu_cdb_val,
    input  logic                in_lsb_cdb_config,
    input  logic [ROB_W-1:0]    in_lsb_cdb_rob_entry,
    input  logic [XLEN-1:0]     in_lsb_cdb_val,
    output logic                out_full,
    output logic                out_config,
    output logic [XLEN-1:0]     out_a,
    output logic [XLEN-1:0]     out_b,
    output logic [XLEN-1:0]     out_PC,
    output logic [XLEN-1:0]     out_imm,
    output logic [OPCODE_W-1:0] out_opcode,
    output logic [FUNCT3_W-1:0] out_precise,
    output logic [ROB_W-1:0]    out_rob_entry
);

    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0]  busy;
    logic [RS_SIZE-1:0]  qj_busy;
    logic [RS_SIZE-1:0]  qk_busy;
    logic [OPCODE_W-1:0] opcode  [RS_SIZE];
    logic [FUNCT3_W-1:0] precise [RS_SIZE];
    word_t               imm     [RS_SIZE];
    word_t               pc      [RS_SIZE];
    word_t               vj      [RS_SIZE];
    word_t               vk      [RS_SIZE];
    rob_tag_t            rob     [RS_SIZE];
    rob_tag_t            qj      [RS_SIZE];
    rob_tag_t            qk      [RS_SIZE];

    logic [RS_SIZE-1:0] free_vec;
    logic [RS_SIZE-1:0] ready_vec;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   ready_idx;
    logic               free_found;
    logic               ready_found;
    logic               dispatch;

    snoop_t disp_j;
    snoop_t disp_k;
    snoop_t wake_j [RS_SIZE];
    snoop_t wake_k [RS_SIZE];

    // Both selections look only at registered state, so an entry issued this
    // cycle is not reusable until the next one.
    assign out_full  = &busy;
    assign free_vec  = ~busy;
    assign ready_vec = busy & ~qj_busy & ~qk_busy;
    assign dispatch  = in_config & free_found;

    rs_pick #(.N(RS_SIZE)) u_free_pick (
        .req   (free_vec),
        .idx   (free_idx),
        .found (free_found)
    );

    rs_pick #(.N(RS_SIZE)) u_ready_pick (
        .req   (ready_vec),
        .idx   (ready_idx),
        .found (ready_found)
    );

    // Result-bus matches for the incoming micro-op and for every stored operand.
    always_comb begin
        disp_j = cdb_snoop(in_Qj, in_alu_cdb_config, in_alu_cdb_rob_entry, in_alu_cdb_val,
                           in_lsb_cdb_config, in_lsb_cdb_rob_entry, in_lsb_cdb_val);
        disp_k = cdb_snoop(in_Qk, in_alu_cdb_config, in_alu_cdb_rob_entry, in_alu_cdb_val,
                           in_lsb_cdb_config, in_lsb_cdb_rob_entry, in_lsb_cdb_val);
        for (int i = 0; i < RS_SIZE; i++) begin
            wake_j[i] = cdb_snoop(qj[i], in_alu_cdb_config, in_alu_cdb_rob_entry, in_alu_cdb_val,
                                  in_lsb_cdb_config, in_lsb_cdb_rob_entry, in_lsb_cdb_val);
            wake_k[i] = cdb_snoop(qk[i], in_alu_cdb_config, in_alu_cdb_rob_entry, in_alu_cdb_val,
                                  in_lsb_cdb_config, in_lsb_cdb_rob_entry, in_lsb_cdb_val);
        end
    end

    // Entry storage: flush, wakeup, dispatch and issue-release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= {RS_SIZE{1'b0}};
            qj_busy <= {RS_SIZE{1'b0}};
            qk_busy <= {RS_SIZE{1'b0}};
            for (int i = 0; i < RS_SIZE; i++) begin
                opcode[i]  <= {OPCODE_W{1'b0}};
                precise[i] <= {FUNCT3_W{1'b0}};
                imm[i]     <= {XLEN{1'b0}};
                pc[i]      <= {XLEN{1'b0}};
                vj[i]      <= {XLEN{1'b0}};
                vk[i]      <= {XLEN{1'b0}};
                rob[i]     <= {ROB_W{1'b0}};
                qj[i]      <= {ROB_W{1'b0}};
                qk[i]      <= {ROB_W{1'b0}};
            end
        end else if (rdy) begin
            if (rollback_config) begin
                busy <= {RS_SIZE{1'b0}};
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy[i] && qj_busy[i] && wake_j[i].hit) begin
                        vj[i]      <= wake_j[i].val;
                        qj_busy[i] <= 1'b0;
                    end
                    if (busy[i] && qk_busy[i] && wake_k[i].hit) begin
                        vk[i]      <= wake_k[i].val;
                        qk_busy[i] <= 1'b0;
                    end
                end

                // The free slot is never busy, so it cannot collide with a
                // wakeup or with the issuing slot above.
                if (dispatch) begin
                    busy[free_idx]    <= 1'b1;
                    opcode[free_idx]  <= in_opcode;
                    precise[free_idx] <= in_precise;
                    imm[free_idx]     <= in_imm;
                    pc[free_idx]      <= in_PC;
                    rob[free_idx]     <= in_rob_entry;
                    qj[free_idx]      <= in_Qj;
                    qk[free_idx]      <= in_Qk;
                    qj_busy[free_idx] <= in_Qj_busy & ~disp_j.hit;
                    qk_busy[free_idx] <= in_Qk_busy & ~disp_k.hit;
                    vj[free_idx]      <= (in_Qj_busy && disp_j.hit) ? disp_j.val : in_Vj;
                    vk[free_idx]      <= (in_Qk_busy && disp_k.hit) ? disp_k.val : in_Vk;
                end

                if (ready_found) begin
                    busy[ready_idx] <= 1'b0;
                end
            end
        end
    end

    // Issue register toward the ALU; payload holds when nothing issues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_config    <= 1'b0;
            out_a         <= {XLEN{1'b0}};
            out_b         <= {XLEN{1'b0}};
            out_PC        <= {XLEN{1'b0}};
            out_imm       <= {XLEN{1'b0}};
            out_opcode    <= {OPCODE_W{1'b0}};
            out_precise   <= {FUNCT3_W{1'b0}};
            out_rob_entry <= {ROB_W{1'b0}};
        end else if (rdy) begin
            if (rollback_config) begin
                out_config <= 1'b0;
            end else if (ready_found) begin
                out_config    <= 1'b1;
                out_a         <= vj[ready_idx];
                out_b         <= vk[ready_idx];
                out_PC        <= pc[ready_idx];
                out_imm       <= imm[ready_idx];
                out_opcode    <= opcode[ready_idx];
                out_precise   <= precise[ready_idx];
                out_rob_entry <= rob[ready_idx];
            end else begin
                out_config <= 1'b0;
            end
        end
    end

endmodule
